btb_assoc: RTL and testbench

Parametrised set-associative Branch Target Buffer with per-entry saturating direction counters and per-set round-robin replacement.
- Sits beside the fetch-stage PC register: combinational lookup of the current fetch PC returns hit, predicted direction and target.
- Synchronous update port is driven from the branch-resolution stage.
- Generalises the direct-mapped, always-taken BTB: WAYS=1 with counters ignored degenerates to it.

---
 rtl/btb_assoc_if.sv | 45 ++++
 rtl/btb_assoc.sv | 217 +++++++++++++++++++++
 tb/tb_btb_assoc.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/btb_assoc_if.sv
// ---------------------------------------------------------------------------
// btb_assoc_if -- signal bundle between the fetch/resolve logic and the BTB.
//
// Lookup side (fetch stage):
//   lookup_en      qualifies a lookup (statistics only)
//   PC_in          fetch PC to look up
//   hit            a valid way of the indexed set holds the PC's tag
//   predict_taken  hit AND MSB of that way's direction counter
//   target_addr    stored target when hit, else 0
// Update side (branch-resolution stage):
//   upd_valid      a resolved branch is presented this cycle
//   upd_PC         PC of the resolved branch
//   upd_taken      actual direction
//   upd_target     actual target (written only when upd_taken=1)
// Control:
//   flush          synchronous invalidate of all entries
//
// Update handshake: there is no ready. An update is a single-cycle pulse.
// It is accepted on every rising edge where upd_valid=1, unless rst or flush
// is high in that same cycle. In that case the update is silently dropped.
//
// Modports: master = fetch/resolve side (drives requests), slave = BTB.
// ---------------------------------------------------------------------------
interface btb_assoc_if;
    logic        flush;
    logic        lookup_en;
    logic [31:0] PC_in;
    logic        hit;
    logic        predict_taken;
    logic [31:0] target_addr;
    logic        upd_valid;
    logic [31:0] upd_PC;
    logic        upd_taken;
    logic [31:0] upd_target;

    modport master (
        output flush, lookup_en, PC_in, upd_valid, upd_PC, upd_taken, upd_target,
        input  hit, predict_taken, target_addr
    );

    modport slave (
        input  flush, lookup_en, PC_in, upd_valid, upd_PC, upd_taken, upd_target,
        output hit, predict_taken, target_addr
    );
endinterface

// File: rtl/btb_assoc.sv
// ---------------------------------------------------------------------------
// btb_assoc -- set-associative Branch Target Buffer.
//
// Each entry holds a per-entry saturating direction counter, and each set has
// its own round-robin replacement pointer. Lookup is purely combinational on
// the fetch PC. Training and allocation happen on the clock edge from the
// resolution-stage update port. Storage is flop-based, so the lookup path
// has no read latency.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous active-high reset (valid bits, rr pointers, stats)
//   bus           btb_assoc_if.slave (lookup, update and flush signals)
//   stat_lookups  [BTB_ASSOC_STATS_EN only] cycles with lookup_en=1
//   stat_hits     [BTB_ASSOC_STATS_EN only] cycles with lookup_en=1 && hit=1
//
// Optional feature macro: BTB_ASSOC_STATS_EN adds the two 32-bit
// wrap-around statistic counters. These are cleared by rst only, not by flush.
//
// PC slicing: index = PC[IDX_W+1:2], tag = PC[31:IDX_W+2], PC[1:0] ignored.
// ---------------------------------------------------------------------------
module btb_assoc #(
    parameter int SETS      = 64,
    parameter int WAYS      = 2,
    parameter int CNT_WIDTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    btb_assoc_if.slave  bus
`ifdef BTB_ASSOC_STATS_EN
    ,
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_hits
`endif
);

    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_W = 30 - IDX_W;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    // A fresh allocation starts weakly taken.
    localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'(1) << (CNT_WIDTH - 1);

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    logic [WAYS-1:0]      valid_q [SETS];
    logic [TAG_W-1:0]     tag_q   [SETS][WAYS];
    logic [31:0]          tgt_q   [SETS][WAYS];
    logic [CNT_WIDTH-1:0] cnt_q   [SETS][WAYS];
    logic [WAY_W-1:0]     rr_q    [SETS];

    // -----------------------------------------------------------------------
    // Lookup (combinational, reads pre-update contents)
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;
    logic [WAY_W-1:0] lk_way;

    assign lk_idx = bus.PC_in[IDX_W+1:2];
    assign lk_tag = bus.PC_in[31:IDX_W+2];

    // The update rules guarantee that at most one way matches. The loop
    // therefore does not need a priority encoder.
    always_comb begin
        lk_hit = 1'b0;
        lk_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
                lk_hit = 1'b1;
                lk_way = WAY_W'(w);
            end
        end
    end

    assign bus.hit           = lk_hit;
    assign bus.predict_taken = lk_hit & cnt_q[lk_idx][lk_way][CNT_WIDTH-1];
    assign bus.target_addr   = lk_hit ? tgt_q[lk_idx][lk_way] : 32'h0;

    // -----------------------------------------------------------------------
    // Update decode
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0]     up_idx;
    logic [TAG_W-1:0]     up_tag;
    logic                 up_hit;
    logic [WAY_W-1:0]     up_way;
    logic                 inv_found;
    logic [WAY_W-1:0]     inv_way;
    logic [WAY_W-1:0]     victim;
    logic [WAY_W-1:0]     rr_d;
    logic [CNT_WIDTH-1:0] cnt_cur;
    logic [CNT_WIDTH-1:0] cnt_d;
    logic                 upd_go;
    logic                 do_train;
    logic                 do_alloc;

    assign up_idx = bus.upd_PC[IDX_W+1:2];
    assign up_tag = bus.upd_PC[31:IDX_W+2];

    always_comb begin
        up_hit    = 1'b0;
        up_way    = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        // Scan downwards so that the lowest-numbered invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[up_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[up_idx][w] && (tag_q[up_idx][w] == up_tag)) begin
                up_hit = 1'b1;
                up_way = WAY_W'(w);
            end
        end
    end

    // If the set still has an invalid way, that way is the victim. Otherwise
    // the round-robin pointer selects the victim.
    assign victim = inv_found ? inv_way : rr_q[up_idx];

    // The pointer advances modulo WAYS. It also works for WAYS values that
    // are not a power of two, and it stays at 0 when WAYS=1.
    assign rr_d = (rr_q[up_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[up_idx] + 1'b1;

    // Saturating counter training.
    assign cnt_cur = cnt_q[up_idx][up_way];
    always_comb begin
        cnt_d = cnt_cur;
        if (bus.upd_taken) begin
            if (cnt_cur != CNT_MAX) cnt_d = cnt_cur + 1'b1;
        end else begin
            if (cnt_cur != CNT_ZERO) cnt_d = cnt_cur - 1'b1;
        end
    end

    // rst and flush both take priority over an update and drop it.
    assign upd_go   = bus.upd_valid && !rst && !bus.flush;
    assign do_train = upd_go && up_hit;
    assign do_alloc = upd_go && !up_hit && bus.upd_taken;

    // -----------------------------------------------------------------------
    // Control state: valid bits and replacement pointers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (do_alloc) begin
            valid_q[up_idx][victim] <= 1'b1;
            // The pointer moves only when a full set is overwritten.
            if (!inv_found) rr_q[up_idx] <= rr_d;
        end
    end

    // -----------------------------------------------------------------------
    // Payload: tags, targets, counters. These have no reset. Stale values
    // behind a cleared valid bit are harmless.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            tag_q[up_idx][victim] <= up_tag;
            tgt_q[up_idx][victim] <= bus.upd_target;
            cnt_q[up_idx][victim] <= CNT_INIT;
        end else if (do_train) begin
            cnt_q[up_idx][up_way] <= cnt_d;
            if (bus.upd_taken) tgt_q[up_idx][up_way] <= bus.upd_target;
        end
    end

    // -----------------------------------------------------------------------
    // Statistics
    // -----------------------------------------------------------------------
`ifdef BTB_ASSOC_STATS_EN
    logic [31:0] stat_lookups_q, stat_lookups_d;
    logic [31:0] stat_hits_q,    stat_hits_d;

    always_comb begin
        stat_lookups_d = stat_lookups_q;
        stat_hits_d    = stat_hits_q;
        if (bus.lookup_en) begin
            stat_lookups_d = stat_lookups_q + 32'd1;
            if (lk_hit) stat_hits_d = stat_hits_q + 32'd1;
        end
    end

    // The counters are cleared only by rst. flush leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_lookups_q <= '0;
            stat_hits_q    <= '0;
        end else begin
            stat_lookups_q <= stat_lookups_d;
            stat_hits_q    <= stat_hits_d;
        end
    end

    assign stat_lookups = stat_lookups_q;
    assign stat_hits    = stat_hits_q;
`else
    // lookup_en only feeds the statistics, which are absent in this build.
    logic unused_lookup_en;
    assign unused_lookup_en = bus.lookup_en;
`endif

    // Byte-offset bits never take part in indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{bus.PC_in[1:0], bus.upd_PC[1:0]};

endmodule

// File: tb/tb_btb_assoc.sv
// ---------------------------------------------------------------------------
// tb_btb_assoc -- directed bench for btb_assoc (SETS=64, WAYS=2, CNT_WIDTH=2).
// ---------------------------------------------------------------------------
module tb_btb_assoc;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    btb_assoc_if bus ();

`ifdef BTB_ASSOC_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_hits;
`endif

    btb_assoc #(.SETS(64), .WAYS(2), .CNT_WIDTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
`ifdef BTB_ASSOC_STATS_EN
        ,
        .stat_lookups (stat_lookups),
        .stat_hits    (stat_hits)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Checking
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drivers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        bus.upd_PC     = pc;
        bus.upd_taken  = taken;
        bus.upd_target = tgt;
        bus.upd_valid  = 1'b1;
        step();
        bus.upd_valid  = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_hit,
                        input logic exp_pt, input logic [31:0] exp_tgt);
        bus.PC_in = pc;
        #1;
        chk({tag, ".hit"}, {31'd0, bus.hit}, {31'd0, exp_hit});
        chk({tag, ".pt"},  {31'd0, bus.predict_taken}, {31'd0, exp_pt});
        chk({tag, ".tgt"}, bus.target_addr, exp_tgt);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.lookup_en = 1'b0;
        bus.PC_in     = 32'h0;
        bus.upd_valid = 1'b0;
        bus.upd_PC    = 32'h0;
        bus.upd_taken = 1'b0;
        bus.upd_target = 32'h0;
        step();
        step();
        rst = 1'b0;

        // 1. Reset state
        look("rst", 32'h0000_0100, 1'b0, 1'b0, 32'h0);

        // 2. Allocate; a lookup in the same cycle still sees the old contents
        bus.upd_PC     = 32'h100;
        bus.upd_taken  = 1'b1;
        bus.upd_target = 32'h200;
        bus.upd_valid  = 1'b1;
        look("alloc_same_cycle", 32'h100, 1'b0, 1'b0, 32'h0);
        step();
        bus.upd_valid = 1'b0;
        look("alloc_next", 32'h100, 1'b1, 1'b1, 32'h200);

        // 3. Counter walk: not-taken x3 -> 1,0,0 (target must stay unchanged)
        upd(32'h100, 1'b0, 32'hDEAD_0000);
        look("nt1", 32'h100, 1'b1, 1'b0, 32'h200);
        upd(32'h100, 1'b0, 32'hDEAD_0000);
        look("nt2", 32'h100, 1'b1, 1'b0, 32'h200);
        upd(32'h100, 1'b0, 32'hDEAD_0000);
        look("nt3", 32'h100, 1'b1, 1'b0, 32'h200);
        // taken x4 -> 1,2,3,3; the last one rewrites the target
        upd(32'h100, 1'b1, 32'h200);
        look("t1", 32'h100, 1'b1, 1'b0, 32'h200);
        upd(32'h100, 1'b1, 32'h200);
        look("t2", 32'h100, 1'b1, 1'b1, 32'h200);
        upd(32'h100, 1'b1, 32'h200);
        look("t3", 32'h100, 1'b1, 1'b1, 32'h200);
        upd(32'h100, 1'b1, 32'h204);
        look("t4", 32'h100, 1'b1, 1'b1, 32'h204);
        // The counter saturated at 3, so one not-taken leaves it at 2
        upd(32'h100, 1'b0, 32'hDEAD_0000);
        look("sat_nt", 32'h100, 1'b1, 1'b1, 32'h204);

        // A not-taken miss must not allocate; another set stays empty
        upd(32'h504, 1'b0, 32'h900);
        look("nt_miss", 32'h504, 1'b0, 1'b0, 32'h0);
        look("other_set", 32'h104, 1'b0, 1'b0, 32'h0);

        // 4. Replacement in set 0
        upd(32'h100, 1'b1, 32'h204);
        upd(32'h200, 1'b1, 32'h1200);
        upd(32'h300, 1'b1, 32'h1300);
        look("evict_100", 32'h100, 1'b0, 1'b0, 32'h0);
        look("keep_200",  32'h200, 1'b1, 1'b1, 32'h1200);
        look("new_300",   32'h300, 1'b1, 1'b1, 32'h1300);
        upd(32'h400, 1'b1, 32'h1400);
        look("evict_200", 32'h200, 1'b0, 1'b0, 32'h0);
        look("keep_300",  32'h300, 1'b1, 1'b1, 32'h1300);
        look("new_400",   32'h400, 1'b1, 1'b1, 32'h1400);

        // 5. Flush and priority
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        look("fl_100", 32'h100, 1'b0, 1'b0, 32'h0);
        look("fl_200", 32'h200, 1'b0, 1'b0, 32'h0);
        look("fl_300", 32'h300, 1'b0, 1'b0, 32'h0);
        look("fl_400", 32'h400, 1'b0, 1'b0, 32'h0);

        bus.flush = 1'b1;
        upd(32'h500, 1'b1, 32'h1500);
        bus.flush = 1'b0;
        look("flush_drop", 32'h500, 1'b0, 1'b0, 32'h0);

        rst = 1'b1;
        upd(32'h500, 1'b1, 32'h1500);
        rst = 1'b0;
        look("rst_drop", 32'h500, 1'b0, 1'b0, 32'h0);

        // The table works again after the dropped updates
        upd(32'h500, 1'b1, 32'h1500);
        look("post_alloc", 32'h500, 1'b1, 1'b1, 32'h1500);

`ifdef BTB_ASSOC_STATS_EN
        // 6. Statistics
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("stat_rst_lk", stat_lookups, 32'd0);
        upd(32'h100, 1'b1, 32'h2100);
        upd(32'h200, 1'b1, 32'h2200);
        for (int i = 0; i < 10; i++) begin
            bus.lookup_en = 1'b1;
            bus.PC_in = (i < 4) ? ((i % 2 == 0) ? 32'h100 : 32'h200) : 32'h300 + 32'(i) * 4;
            step();
        end
        bus.lookup_en = 1'b0;
        chk("stat_lookups", stat_lookups, 32'd10);
        chk("stat_hits",    stat_hits,    32'd4);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("stat_fl_lk",  stat_lookups, 32'd10);
        chk("stat_fl_hit", stat_hits,    32'd4);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("stat_rst_lk2",  stat_lookups, 32'd0);
        chk("stat_rst_hit2", stat_hits,    32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
